// File: rtl/self_destruct_sequencer.sv
// ---------------------------------------------------------------------------------------------
// self_destruct_sequencer
//
// Sequences the self-destruct path:
//   IDLE -> ARMING -> COUNTDOWN -> FIRE -> DEAD.
// In IDLE the sequencer waits for combat and danger together. ARMING requires both to hold for
// ARM_TICKS ticks. COUNTDOWN then drops one LED per STEP_TICKS ticks from a thermometer value,
// blinking the bar with a BLINK_TICKS half-period. FIRE holds a level request until the actuator
// acknowledges it. DEAD is sticky until reset.
//
// Ports
//   clk        system clock
//   reset      synchronous, active-low reset (overrides every state, including DEAD)
//   tick       one-cycle timebase strobe; all timing counters advance only on tick
//   in_combat  debounced in-combat status
//   in_danger  qualified danger flag
//   abort_req  one-cycle operator abort strobe
//   fire_ack   actuator acknowledge
//   fire_req   fire request, held until fire_ack is sampled in FIRE
//   state      0 IDLE, 1 ARMING, 2 COUNTDOWN, 3 FIRE, 4 DEAD
//   remaining  thermometer countdown value, FF down to 00
//   leds       LED bank drive
//   dead       sticky destroyed flag
//
// Every output is a flop, so a condition sampled at edge N is visible just after edge N.
// ---------------------------------------------------------------------------------------------
module self_destruct_sequencer #(
  parameter int unsigned ARM_TICKS   = 50,
  parameter int unsigned STEP_TICKS  = 100,
  parameter int unsigned BLINK_TICKS = 33
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tick,
  input  logic       in_combat,
  input  logic       in_danger,
  input  logic       abort_req,
  input  logic       fire_ack,
  output logic       fire_req,
  output logic [2:0] state,
  output logic [7:0] remaining,
  output logic [7:0] leds,
  output logic       dead
);

  // Counter widths follow the terminal counts; a 1-tick parameter still needs a 1-bit counter.
  localparam int unsigned ArmW   = (ARM_TICKS   > 1) ? $clog2(ARM_TICKS)   : 1;
  localparam int unsigned StepW  = (STEP_TICKS  > 1) ? $clog2(STEP_TICKS)  : 1;
  localparam int unsigned BlinkW = (BLINK_TICKS > 1) ? $clog2(BLINK_TICKS) : 1;

  localparam logic [ArmW-1:0]   ArmLast   = ArmW'(ARM_TICKS - 1);
  localparam logic [StepW-1:0]  StepLast  = StepW'(STEP_TICKS - 1);
  localparam logic [BlinkW-1:0] BlinkLast = BlinkW'(BLINK_TICKS - 1);

  localparam logic [7:0] RemFull = 8'hFF;
  localparam logic [7:0] LedsOff = 8'h00;
  localparam logic [7:0] LedsOn  = 8'hFF;

  typedef enum logic [2:0] {
    StIdle      = 3'd0,
    StArming    = 3'd1,
    StCountdown = 3'd2,
    StFire      = 3'd3,
    StDead      = 3'd4
  } state_e;

  state_e            state_q, state_d;
  logic [7:0]        remaining_q, remaining_d;
  logic [7:0]        leds_q, leds_d;
  logic              fire_req_q, fire_req_d;
  logic              dead_q, dead_d;
  logic [ArmW-1:0]   arm_cnt_q, arm_cnt_d;
  logic [StepW-1:0]  step_cnt_q, step_cnt_d;
  logic [BlinkW-1:0] blink_cnt_q, blink_cnt_d;
  logic              phase_q, phase_d;

  // ------------------------------------------------------------------------------------------
  // Next-state and registered-output logic
  // ------------------------------------------------------------------------------------------
  always_comb begin
    state_d     = state_q;
    remaining_d = remaining_q;
    leds_d      = leds_q;
    fire_req_d  = fire_req_q;
    dead_d      = dead_q;
    arm_cnt_d   = arm_cnt_q;
    step_cnt_d  = step_cnt_q;
    blink_cnt_d = blink_cnt_q;
    phase_d     = phase_q;

    case (state_q)
      StIdle: begin
        remaining_d = RemFull;
        leds_d      = LedsOff;
        fire_req_d  = 1'b0;
        dead_d      = 1'b0;
        arm_cnt_d   = '0;
        step_cnt_d  = '0;
        blink_cnt_d = '0;
        phase_d     = 1'b1;
        if (tick && in_combat && in_danger) begin
          state_d = StArming;
        end
      end

      StArming: begin
        // Any loss of qualification drops straight back, not waiting for a tick.
        if (abort_req || !in_combat || !in_danger) begin
          state_d   = StIdle;
          arm_cnt_d = '0;
        end else if (tick) begin
          if (arm_cnt_q == ArmLast) begin
            state_d     = StCountdown;
            arm_cnt_d   = '0;
            remaining_d = RemFull;
            step_cnt_d  = '0;
            blink_cnt_d = '0;
            phase_d     = 1'b1;
            leds_d      = RemFull;
          end else begin
            arm_cnt_d = arm_cnt_q + ArmW'(1);
          end
        end
      end

      StCountdown: begin
        // Abort is checked first so it wins over both a final step and the move to FIRE.
        // in_danger is deliberately not looked at: once counting, the sequence is committed.
        if (abort_req || !in_combat) begin
          state_d     = StIdle;
          remaining_d = RemFull;
          leds_d      = LedsOff;
          step_cnt_d  = '0;
          blink_cnt_d = '0;
          phase_d     = 1'b1;
        end else if (remaining_q == 8'h00) begin
          state_d     = StFire;
          fire_req_d  = 1'b1;
          leds_d      = LedsOn;
          step_cnt_d  = '0;
          blink_cnt_d = '0;
          phase_d     = 1'b1;
        end else begin
          if (tick) begin
            if (step_cnt_q == StepLast) begin
              step_cnt_d  = '0;
              remaining_d = remaining_q >> 1;
            end else begin
              step_cnt_d = step_cnt_q + StepW'(1);
            end
            if (blink_cnt_q == BlinkLast) begin
              blink_cnt_d = '0;
              phase_d     = ~phase_q;
            end else begin
              blink_cnt_d = blink_cnt_q + BlinkW'(1);
            end
          end
          // LEDs track the values being registered this edge so they never lag a step.
          leds_d = phase_d ? remaining_d : LedsOff;
        end
      end

      StFire: begin
        leds_d      = LedsOn;
        remaining_d = 8'h00;
        if (fire_ack) begin
          state_d    = StDead;
          fire_req_d = 1'b0;
          dead_d     = 1'b1;
        end else begin
          fire_req_d = 1'b1;
        end
      end

      StDead: begin
        fire_req_d  = 1'b0;
        dead_d      = 1'b1;
        leds_d      = LedsOn;
        remaining_d = 8'h00;
      end

      default: begin
        // Unreachable encodings recover to a clean IDLE.
        state_d     = StIdle;
        remaining_d = RemFull;
        leds_d      = LedsOff;
        fire_req_d  = 1'b0;
        dead_d      = 1'b0;
        arm_cnt_d   = '0;
        step_cnt_d  = '0;
        blink_cnt_d = '0;
        phase_d     = 1'b1;
      end
    endcase
  end

  // ------------------------------------------------------------------------------------------
  // State registers, synchronous active-low reset
  // ------------------------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= StIdle;
      remaining_q <= RemFull;
      leds_q      <= LedsOff;
      fire_req_q  <= 1'b0;
      dead_q      <= 1'b0;
      arm_cnt_q   <= '0;
      step_cnt_q  <= '0;
      blink_cnt_q <= '0;
      phase_q     <= 1'b1;
    end else begin
      state_q     <= state_d;
      remaining_q <= remaining_d;
      leds_q      <= leds_d;
      fire_req_q  <= fire_req_d;
      dead_q      <= dead_d;
      arm_cnt_q   <= arm_cnt_d;
      step_cnt_q  <= step_cnt_d;
      blink_cnt_q <= blink_cnt_d;
      phase_q     <= phase_d;
    end
  end

  assign state     = state_q;
  assign remaining = remaining_q;
  assign leds      = leds_q;
  assign fire_req  = fire_req_q;
  assign dead      = dead_q;

endmodule
